// File: rtl/mips_cpu_bus_pkg.sv
// ============================================================================
// Module      : mips_cpu_bus_pkg
// Description : Shared types and owner encodings for the CPU bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_cpu_bus_pkg;

    localparam logic [1:0] C_OWNER_NONE = 2'b00;
    localparam logic [1:0] C_OWNER_I    = 2'b01;
    localparam logic [1:0] C_OWNER_D    = 2'b10;

    // Last-served encoding: low means the instruction port was served last.
    localparam logic       C_LAST_I     = 1'b0;

    // State codes equal the owner codes so the state register drives owner directly.
    typedef enum logic [1:0] {
        IDLE  = C_OWNER_NONE,
        OWN_I = C_OWNER_I,
        OWN_D = C_OWNER_D
    } state_t;

endpackage : mips_cpu_bus_pkg

`default_nettype wire

// File: rtl/mips_cpu_arb_select.sv
// ============================================================================
// Module      : mips_cpu_arb_select
// Description : Combinational next-grant picker; on a tie the port that was
//               not served last wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_cpu_arb_select
    import mips_cpu_bus_pkg::*;
(
    input  logic [1:0] requests,     // [1] data port, [0] instruction port
    input  logic       last_served,
    output state_t     grant
);

    always_comb begin
        grant = IDLE;
        case (requests)
            2'b11:   grant = (last_served == C_LAST_I) ? OWN_D : OWN_I;
            2'b10:   grant = OWN_D;
            2'b01:   grant = OWN_I;
            default: grant = IDLE;
        endcase
    end

endmodule : mips_cpu_arb_select

`default_nettype wire

// File: rtl/mips_cpu_bus_arbiter.sv
// ============================================================================
// Module      : mips_cpu_bus_arbiter
// Description : Arbitrates instruction and data Avalon ports onto one master.
//               Define MIPS_CPU_ARB_RR_EN for round-robin tie breaking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_cpu_bus_arbiter
    import mips_cpu_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    // instruction port
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_waitrequest,
    // data port
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    input  logic [BE_W-1:0]   d_byteenable,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_waitrequest,
    // shared master
    output logic [ADDR_W-1:0] mem_address,
    output logic              memread,
    output logic              memwrite,
    output logic [DATA_W-1:0] memwritedata,
    output logic [BE_W-1:0]   byteenable,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] memreaddata,
    output logic [1:0]        owner
);

    state_t r_state;
    state_t w_next;
    state_t w_grant;
    logic   w_d_req;
    logic   w_owner_req;
    logic   w_complete;
    logic   w_idle_last;
    logic   w_pick_last;

    assign w_d_req     = d_read | d_write;
    assign w_owner_req = ((r_state == OWN_I) & i_read) | ((r_state == OWN_D) & w_d_req);
    assign w_complete  = w_owner_req & ~waitrequest;

`ifdef MIPS_CPU_ARB_RR_EN
    logic r_last_served;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_served <= C_LAST_I;
        end else if (w_complete) begin
            r_last_served <= (r_state == OWN_D);
        end
    end

    assign w_idle_last = r_last_served;
`else
    // Pretending the instruction port was served last yields fixed data priority.
    assign w_idle_last = C_LAST_I;
`endif

    // After a completion the current owner counts as last served, so the other
    // requesting port is handed the bus without an idle bubble.
    assign w_pick_last = (r_state == IDLE) ? w_idle_last : (r_state == OWN_D);

    mips_cpu_arb_select u_select (
        .requests    ({w_d_req, i_read}),
        .last_served (w_pick_last),
        .grant       (w_grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: w_next = w_grant;
            OWN_I, OWN_D: begin
                if (!w_owner_req) begin
                    w_next = IDLE;
                end else if (w_complete) begin
                    w_next = w_grant;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_address  = '0;
        memread      = 1'b0;
        memwrite     = 1'b0;
        memwritedata = '0;
        byteenable   = '0;
        case (r_state)
            OWN_I: begin
                mem_address = i_address;
                memread     = i_read;
                byteenable  = '1;
            end
            OWN_D: begin
                mem_address  = d_address;
                memread      = d_read & ~d_write;
                memwrite     = d_write;
                memwritedata = d_writedata;
                byteenable   = d_byteenable;
            end
            default: ;
        endcase
    end

    assign i_waitrequest = i_read  & ((r_state != OWN_I) | waitrequest);
    assign d_waitrequest = w_d_req & ((r_state != OWN_D) | waitrequest);

    assign i_readdata = memreaddata;
    assign d_readdata = memreaddata;
    assign owner      = r_state;

endmodule : mips_cpu_bus_arbiter

`default_nettype wire

// File: tb/tb_mips_cpu_bus_arbiter.sv
// ============================================================================
// Module      : tb_mips_cpu_bus_arbiter
// Description : Self-checking bench for mips_cpu_bus_arbiter (scoreboard of
//               per-cycle expected bus/port values).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_cpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_read;
    logic [31:0] i_address;
    logic [31:0] i_readdata;
    logic        i_waitrequest;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic [31:0] d_readdata;
    logic        d_waitrequest;
    logic [31:0] mem_address;
    logic        memread;
    logic        memwrite;
    logic [31:0] memwritedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] memreaddata;
    logic [1:0]  owner;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mips_cpu_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .BE_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_read        (i_read),
        .i_address     (i_address),
        .i_readdata    (i_readdata),
        .i_waitrequest (i_waitrequest),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_address     (d_address),
        .d_writedata   (d_writedata),
        .d_byteenable  (d_byteenable),
        .d_readdata    (d_readdata),
        .d_waitrequest (d_waitrequest),
        .mem_address   (mem_address),
        .memread       (memread),
        .memwrite      (memwrite),
        .memwritedata  (memwritedata),
        .byteenable    (byteenable),
        .waitrequest   (waitrequest),
        .memreaddata   (memreaddata),
        .owner         (owner)
    );

    typedef struct packed {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        wt;
        logic        rs;
    } stim_t;

    typedef struct packed {
        logic [1:0]  own;
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        iw;
        logic        dw;
        logic [31:0] ri;
        logic [31:0] rdd;
    } exp_t;

    exp_t sb[$];

    function automatic stim_t S(logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                                logic [31:0] wd, logic [3:0] be, logic wt, logic rs);
        stim_t s;
        s = '{ir, ia, dr, dw, da, wd, be, wt, rs};
        return s;
    endfunction

    function automatic exp_t E(logic [1:0] own, logic rd, logic wr, logic [3:0] be,
                               logic [31:0] addr, logic [31:0] wd, logic iw, logic dw);
        exp_t e;
        e = '{own, rd, wr, be, addr, wd, iw, dw, 32'h0, 32'h0};
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o = '{owner, memread, memwrite, byteenable, mem_address, memwritedata,
              i_waitrequest, d_waitrequest, i_readdata, d_readdata};
        return o;
    endfunction

    // Called just after a posedge: inputs at +1, reset at +3 (before the sampling negedge).
    task automatic apply(stim_t s);
        #1;
        i_read       = s.ir;
        i_address    = s.ia;
        d_read       = s.dr;
        d_write      = s.dw;
        d_address    = s.da;
        d_writedata  = s.wd;
        d_byteenable = s.be;
        waitrequest  = s.wt;
        #2;
        reset        = s.rs;
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e, o;
        st.push_back(S(1, 32'h100, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(E(0, 0, 0, 0, 0, 0, 1, 0));
        st.push_back(S(0, 0, 1, 0, 32'h8, 0, 4'hF, 0, 1)); ex.push_back(E(0, 0, 0, 0, 0, 0, 0, 1));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0));        ex.push_back(E(0, 0, 0, 0, 0, 0, 0, 0));
        memreaddata = 32'h1234_5678;
        for (int k = 0; k < st.size(); k++) begin
            apply(st[k]);
            e = ex[k]; e.ri = 32'h1234_5678; e.rdd = 32'h1234_5678;
            sb.push_back(e);
            @(negedge clk);
            o = observe();
            e = sb.pop_front();
            n_total++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset cyc%0d got=%h want=%h", k, o, e);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_single_read();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e, o;
        st.push_back(S(1, 32'hBFC0_0000, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 0, 0, 0, 1, 0));
        st.push_back(S(1, 32'hBFC0_0000, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(1, 1, 0, 4'hF, 32'hBFC0_0000, 0, 0, 0));
        st.push_back(S(0, 32'hBFC0_0000, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(1, 0, 0, 4'hF, 32'hBFC0_0000, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0));             ex.push_back(E(0, 0, 0, 0, 0, 0, 0, 0));
        memreaddata = 32'hCAFE_0001;
        for (int k = 0; k < st.size(); k++) begin
            apply(st[k]);
            e = ex[k]; e.ri = 32'hCAFE_0001; e.rdd = 32'hCAFE_0001;
            sb.push_back(e);
            @(negedge clk);
            o = observe();
            e = sb.pop_front();
            n_total++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL single_read cyc%0d got=%h want=%h", k, o, e);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_tie();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e, o;
        st.push_back(S(1, 32'h400, 0, 1, 32'h1000, 32'hDEAD_BEEF, 4'h3, 0, 0));
        ex.push_back(E(0, 0, 0, 0, 0, 0, 1, 1));
        st.push_back(S(1, 32'h400, 0, 1, 32'h1000, 32'hDEAD_BEEF, 4'h3, 0, 0));
        ex.push_back(E(2, 0, 1, 4'h3, 32'h1000, 32'hDEAD_BEEF, 1, 0));
        st.push_back(S(1, 32'h400, 0, 0, 32'h1000, 32'hDEAD_BEEF, 4'h3, 0, 0));
        ex.push_back(E(1, 1, 0, 4'hF, 32'h400, 0, 0, 0));
        st.push_back(S(0, 32'h400, 0, 0, 0, 0, 0, 0, 0));
        ex.push_back(E(1, 0, 0, 4'hF, 32'h400, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0));
        ex.push_back(E(0, 0, 0, 0, 0, 0, 0, 0));
        memreaddata = 32'h0BAD_F00D;
        for (int k = 0; k < st.size(); k++) begin
            apply(st[k]);
            e = ex[k]; e.ri = 32'h0BAD_F00D; e.rdd = 32'h0BAD_F00D;
            sb.push_back(e);
            @(negedge clk);
            o = observe();
            e = sb.pop_front();
            n_total++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL tie cyc%0d got=%h want=%h", k, o, e);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_stall();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e, o;
        st.push_back(S(1, 32'h2000, 0, 0, 0, 0, 0, 1, 0));
        ex.push_back(E(0, 0, 0, 0, 0, 0, 1, 0));
        for (int j = 0; j < 3; j++) begin
            st.push_back(S(1, 32'h2000, 1, 0, 32'h3000, 0, 4'h5, 1, 0));
            ex.push_back(E(1, 1, 0, 4'hF, 32'h2000, 0, 1, 1));
        end
        st.push_back(S(1, 32'h2000, 1, 0, 32'h3000, 0, 4'h5, 0, 0));
        ex.push_back(E(1, 1, 0, 4'hF, 32'h2000, 0, 0, 1));
        st.push_back(S(0, 0, 1, 0, 32'h3000, 0, 4'h5, 0, 0));
        ex.push_back(E(2, 1, 0, 4'h5, 32'h3000, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 32'h3000, 0, 4'h5, 0, 0));
        ex.push_back(E(2, 0, 0, 4'h5, 32'h3000, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0));
        ex.push_back(E(0, 0, 0, 0, 0, 0, 0, 0));
        memreaddata = 32'h5555_AAAA;
        for (int k = 0; k < st.size(); k++) begin
            apply(st[k]);
            e = ex[k]; e.ri = 32'h5555_AAAA; e.rdd = 32'h5555_AAAA;
            sb.push_back(e);
            @(negedge clk);
            o = observe();
            e = sb.pop_front();
            n_total++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL stall cyc%0d got=%h want=%h", k, o, e);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_rw_both();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e, o;
        st.push_back(S(0, 0, 1, 1, 32'h80, 32'hA5A5_A5A5, 4'hC, 0, 0));
        ex.push_back(E(0, 0, 0, 0, 0, 0, 0, 1));
        st.push_back(S(0, 0, 1, 1, 32'h80, 32'hA5A5_A5A5, 4'hC, 0, 0));
        ex.push_back(E(2, 0, 1, 4'hC, 32'h80, 32'hA5A5_A5A5, 0, 0));
        st.push_back(S(0, 0, 0, 0, 32'h80, 32'hA5A5_A5A5, 4'hC, 0, 0));
        ex.push_back(E(2, 0, 0, 4'hC, 32'h80, 32'hA5A5_A5A5, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0));
        ex.push_back(E(0, 0, 0, 0, 0, 0, 0, 0));
        memreaddata = 32'h7777_0000;
        for (int k = 0; k < st.size(); k++) begin
            apply(st[k]);
            e = ex[k]; e.ri = 32'h7777_0000; e.rdd = 32'h7777_0000;
            sb.push_back(e);
            @(negedge clk);
            o = observe();
            e = sb.pop_front();
            n_total++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL rw_both cyc%0d got=%h want=%h", k, o, e);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset_mid();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e, o;
        st.push_back(S(0, 0, 0, 1, 32'h44, 32'h1111_2222, 4'hF, 1, 0));
        ex.push_back(E(0, 0, 0, 0, 0, 0, 0, 1));
        st.push_back(S(0, 0, 0, 1, 32'h44, 32'h1111_2222, 4'hF, 1, 0));
        ex.push_back(E(2, 0, 1, 4'hF, 32'h44, 32'h1111_2222, 0, 1));
        st.push_back(S(0, 0, 0, 1, 32'h44, 32'h1111_2222, 4'hF, 1, 1));
        ex.push_back(E(0, 0, 0, 0, 0, 0, 0, 1));
        st.push_back(S(0, 0, 0, 1, 32'h44, 32'h1111_2222, 4'hF, 1, 1));
        ex.push_back(E(0, 0, 0, 0, 0, 0, 0, 1));
        st.push_back(S(0, 0, 0, 1, 32'h44, 32'h1111_2222, 4'hF, 1, 0));
        ex.push_back(E(0, 0, 0, 0, 0, 0, 0, 1));
        st.push_back(S(0, 0, 0, 1, 32'h44, 32'h1111_2222, 4'hF, 1, 0));
        ex.push_back(E(2, 0, 1, 4'hF, 32'h44, 32'h1111_2222, 0, 1));
        st.push_back(S(0, 0, 0, 0, 32'h44, 32'h1111_2222, 4'hF, 0, 0));
        ex.push_back(E(2, 0, 0, 4'hF, 32'h44, 32'h1111_2222, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0));
        ex.push_back(E(0, 0, 0, 0, 0, 0, 0, 0));
        memreaddata = 32'h0000_FFFF;
        for (int k = 0; k < st.size(); k++) begin
            apply(st[k]);
            e = ex[k]; e.ri = 32'h0000_FFFF; e.rdd = 32'h0000_FFFF;
            sb.push_back(e);
            @(negedge clk);
            o = observe();
            e = sb.pop_front();
            n_total++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset_mid cyc%0d got=%h want=%h", k, o, e);
            end
            @(posedge clk);
        end
    endtask

    // Data served alone, then a tie from IDLE: fixed priority repeats data,
    // round-robin hands the bus to the instruction port.
    task automatic test_back_to_back();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e, o;
        st.push_back(S(0, 0, 0, 1, 32'h10, 32'h1, 4'hF, 0, 0));
        ex.push_back(E(0, 0, 0, 0, 0, 0, 0, 1));
        st.push_back(S(0, 0, 0, 1, 32'h10, 32'h1, 4'hF, 0, 0));
        ex.push_back(E(2, 0, 1, 4'hF, 32'h10, 32'h1, 0, 0));
        st.push_back(S(0, 0, 0, 0, 32'h10, 32'h1, 4'hF, 0, 0));
        ex.push_back(E(2, 0, 0, 4'hF, 32'h10, 32'h1, 0, 0));
        st.push_back(S(1, 32'h20, 0, 1, 32'h10, 32'h1, 4'hF, 0, 0));
        ex.push_back(E(0, 0, 0, 0, 0, 0, 1, 1));
        st.push_back(S(1, 32'h20, 0, 1, 32'h10, 32'h1, 4'hF, 0, 0));
        st.push_back(S(0, 32'h20, 0, 0, 32'h10, 32'h1, 4'hF, 0, 0));
`ifdef MIPS_CPU_ARB_RR_EN
        ex.push_back(E(1, 1, 0, 4'hF, 32'h20, 0, 0, 1));
        ex.push_back(E(2, 0, 0, 4'hF, 32'h10, 32'h1, 0, 0));
`else
        ex.push_back(E(2, 0, 1, 4'hF, 32'h10, 32'h1, 1, 0));
        ex.push_back(E(1, 0, 0, 4'hF, 32'h20, 0, 0, 0));
`endif
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0));
        ex.push_back(E(0, 0, 0, 0, 0, 0, 0, 0));
        memreaddata = 32'h3C3C_C3C3;
        for (int k = 0; k < st.size(); k++) begin
            apply(st[k]);
            e = ex[k]; e.ri = 32'h3C3C_C3C3; e.rdd = 32'h3C3C_C3C3;
            sb.push_back(e);
            @(negedge clk);
            o = observe();
            e = sb.pop_front();
            n_total++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL back_to_back cyc%0d got=%h want=%h", k, o, e);
            end
            @(posedge clk);
        end
    endtask

    initial begin
        reset        = 1'b1;
        i_read       = 1'b0;
        i_address    = '0;
        d_read       = 1'b0;
        d_write      = 1'b0;
        d_address    = '0;
        d_writedata  = '0;
        d_byteenable = '0;
        waitrequest  = 1'b0;
        memreaddata  = '0;
        @(posedge clk);
        test_reset();
        test_single_read();
        test_tie();
        test_stall();
        test_rw_both();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_mips_cpu_bus_arbiter

`default_nettype wire
